// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a first-word-fall-through FIFO read port into a valid/ready stream
// through a two-entry skid buffer.
// Ports: rclk/rrst_n clock and async active-low reset; rempty/rdata/rinc FIFO read side;
// out_valid/out_ready/out_data downstream stream; rd_cnt accepted-word count (FIFO_RD_STAT_EN only).
module fifo_rd_stream #(
   parameter int DSIZE = 8
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DSIZE-1:0] out_data
`ifdef FIFO_RD_STAT_EN
   ,output logic [15:0]     rd_cnt
`endif
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   state_t           state, state_n;
   logic [DSIZE-1:0] head, skid, head_n, skid_n;
   logic             push, pop;
   // Pop strobe depends only on registered occupancy, so out_ready never reaches the FIFO.
   assign rinc      = rrst_n && !rempty && (state != FULL);
   assign push      = rinc;
   assign pop       = out_valid && out_ready;
   assign out_valid = state != EMPTY;
   assign out_data  = head;
   always_comb begin
      state_n = state == EMPTY ? (push ? ONE : EMPTY)
              : state == ONE   ? (push && !pop ? FULL : (!push && pop ? EMPTY : ONE))
              : (pop ? ONE : FULL);
      head_n  = ((state == EMPTY && push) || (state == ONE && push && pop)) ? rdata
              : (state == FULL && pop) ? skid : head;
      skid_n  = (state == ONE && push && !pop) ? rdata : skid;
   end
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else begin
         state <= state_n;
         head  <= head_n;
         skid  <= skid_n;
      end
   end
`ifdef FIFO_RD_STAT_EN
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) rd_cnt <= '0;
      else if (pop) rd_cnt <= rd_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench with a queue-based occupancy model of fifo_rd_stream.
module tb_fifo_rd_stream;
   logic       rclk = 1'b0, rrst_n = 1'b0, rempty = 1'b1, out_ready = 1'b0;
   logic [7:0] rdata = 8'h00;
   logic       rinc, out_valid;
   logic [7:0] out_data;
`ifdef FIFO_RD_STAT_EN
   logic [15:0] rd_cnt;
   logic [15:0] cnt_m = 16'd0;
`endif
   int         tests = 0, fails = 0, dut_rinc_cnt = 0;
   logic       last_rinc;
   logic [7:0] src_q[$], buf_q[$], out_log[$];

   fifo_rd_stream #(.DSIZE(8)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef FIFO_RD_STAT_EN
      , .rd_cnt(rd_cnt)
`endif
   );

   always #5 rclk = ~rclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      rempty = src_q.size() == 0;
      rdata  = rempty ? 8'h00 : src_q[0];
   endtask

   // One clock cycle, entered and left at a falling edge; the model advances on its own predictions.
   task automatic cyc(input logic rdy);
      logic e_rinc, e_valid;
      out_ready = rdy;
      drive();
      #1;
      e_rinc  = rrst_n && src_q.size() != 0 && buf_q.size() < 2;
      e_valid = buf_q.size() != 0;
      chk("rinc", rinc, e_rinc);
      chk("out_valid", out_valid, e_valid);
      if (e_valid) chk("out_data", out_data, buf_q[0]);
`ifdef FIFO_RD_STAT_EN
      chk("rd_cnt", rd_cnt, cnt_m);
`endif
      last_rinc = rinc;
      if (rinc) dut_rinc_cnt++;
      if (out_valid && rdy) out_log.push_back(out_data);
      if (e_valid && rdy) begin
         void'(buf_q.pop_front());
`ifdef FIFO_RD_STAT_EN
         cnt_m++;
`endif
      end
      if (e_rinc) buf_q.push_back(src_q.pop_front());
      @(negedge rclk);
   endtask

   // Asynchronous reset pulse starting between edges; FIFO source is reset alongside.
   task automatic pulse_reset();
      #2 rrst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_rinc", rinc, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      buf_q.delete();
      src_q.delete();
`ifdef FIFO_RD_STAT_EN
      cnt_m = 16'd0;
`endif
      @(negedge rclk);
      @(negedge rclk);
      rrst_n = 1'b1;
   endtask

   initial begin
      src_q = {8'h11};
      drive();
      #1;
      chk("init_rinc", rinc, 1'b0);
      chk("init_out_valid", out_valid, 1'b0);
      chk("init_out_data", out_data, 8'h00);
      @(negedge rclk);
      @(negedge rclk);
      rrst_n = 1'b1;
      cyc(1'b1);
      chk("release_rinc", last_rinc, 1'b1);
      repeat (2) cyc(1'b1);
      chk("release_word", out_log.size() == 1 ? out_log[0] : 8'hxx, 8'h11);

      out_log.delete();
      dut_rinc_cnt = 0;
      for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
      repeat (18) cyc(1'b1);
      chk("stream_rinc_cycles", dut_rinc_cnt, 16);
      chk("stream_count", out_log.size(), 16);
      for (int i = 0; i < 16 && i < out_log.size(); i++) chk("stream_order", out_log[i], i + 1);

      out_log.delete();
      dut_rinc_cnt = 0;
      src_q = {8'hA5, 8'h5A, 8'h3C};
      repeat (4) cyc(1'b0);
      chk("bp_pops", dut_rinc_cnt, 2);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_data", out_data, 8'hA5);
      repeat (3) cyc(1'b1);
      chk("bp_count", out_log.size(), 3);
      if (out_log.size() == 3) begin
         chk("bp_w0", out_log[0], 8'hA5);
         chk("bp_w1", out_log[1], 8'h5A);
         chk("bp_w2", out_log[2], 8'h3C);
      end
      cyc(1'b1);

      out_log.delete();
      src_q = {8'h7E};
      repeat (2) cyc(1'b1);
      chk("empty_word", out_log.size() == 1 ? out_log[0] : 8'hxx, 8'h7E);
      chk("empty_valid", out_valid, 1'b0);
      chk("empty_rinc", rinc, 1'b0);
      repeat (2) cyc(1'b1);
      chk("empty_no_extra", out_log.size(), 1);

      out_log.delete();
      src_q = {8'hC1, 8'hC2, 8'hC3};
      repeat (2) cyc(1'b0);
      chk("full_before_rst", out_valid, 1'b1);
      chk("full_no_rinc", rinc, 1'b0);
      pulse_reset();
      repeat (4) cyc(1'b1);
      chk("no_stale", out_log.size(), 0);

`ifdef FIFO_RD_STAT_EN
      pulse_reset();
      for (int i = 0; i < 65537; i++) src_q.push_back(8'(i));
      for (int i = 0; i < 65545 && (src_q.size() != 0 || buf_q.size() != 0); i++) cyc(1'b1);
      cyc(1'b1);
      chk("cnt_wrap", rd_cnt, 16'd1);
      src_q = {8'h99};
      repeat (3) cyc(1'b0);
      chk("cnt_stall", rd_cnt, 16'd1);
      repeat (2) cyc(1'b1);
      chk("cnt_after", rd_cnt, 16'd2);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width in bits.
REQ-002 SHALL have port rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port rrst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rempty  input  1  FIFO read-side empty flag.
REQ-005 SHALL have port rdata  input  DSIZE  FIFO read data; valid whenever rempty=0 (first-word fall-through).
REQ-006 SHALL have port rinc  output  1  FIFO pop strobe; one word is consumed per cycle it is high.
REQ-007 SHALL have port out_valid  output  1  downstream stream valid.
REQ-008 SHALL have port out_ready  input  1  downstream stream ready.
REQ-009 SHALL have port out_data  output  DSIZE  downstream stream data.
REQ-010 SHALL have port rd_cnt  output  16  accepted-word count; present only when FIFO_RD_STAT_EN is defined.

Function
REQ-011 SHALL hold a 2-entry buffer (head, skid) with occupancy state EMPTY(0), ONE(1) or FULL(2).
REQ-012 SHALL drive rinc = rrst_n && !rempty && (state != FULL), decoded from registered state only, never from out_ready.
REQ-013 SHALL define push = rinc and pop = out_valid && out_ready for each cycle.
REQ-014 SHALL drive out_valid = (state != EMPTY) and out_data = head, both straight from registers.
REQ-015 SHALL on push in EMPTY load head <= rdata and go to ONE.
REQ-016 SHALL on push and pop together in ONE load head <= rdata and stay in ONE, sustaining 1 word/cycle.
REQ-017 SHALL on push without pop in ONE load skid <= rdata and go to FULL.
REQ-018 SHALL on pop without push in ONE go to EMPTY; head value is don't-care afterwards.
REQ-019 SHALL on pop in FULL move head <= skid and go to ONE; no push occurs in FULL.
REQ-020 SHALL hold state, head and skid unchanged in all other cases.
REQ-021 SHALL keep out_data stable and out_valid high while out_valid=1 and out_ready=0 (no drop, no reorder).
REQ-022 SHALL give 1-cycle latency: a word popped at edge N appears on out_data after edge N when the buffer was EMPTY.
REQ-023 SHALL deliver words downstream in exact FIFO pop order with no duplication or loss.

Reset
REQ-024 SHALL on rrst_n=0, immediately and independent of rclk, force state=EMPTY, out_valid=0, out_data=0, head=0, skid=0, rinc=0.
REQ-025 SHALL on reset asserted mid-transfer discard buffered words; the FIFO is reset in the same domain by the same rrst_n.
REQ-026 SHALL begin popping on the first rclk edge after rrst_n deasserts if rempty=0.

Configuration
REQ-027 SHALL with macro FIFO_RD_STAT_EN defined include rd_cnt, reset to 0, incremented by 1 on each pop, wrapping 16'hFFFF -> 16'h0000.
REQ-028 SHALL with FIFO_RD_STAT_EN undefined omit the rd_cnt port and counter logic; all other behaviour identical.

Verification
REQ-029 SHALL verify reset: rrst_n=0 with rempty=0 -> rinc=0, out_valid=0, out_data=0; release -> rinc=1 on the next cycle.
REQ-030 SHALL verify streaming: FIFO holds 8'h01..8'h10, out_ready=1 constant -> 16 consecutive out_valid cycles carrying 01..10 in order, rinc high 16 cycles.
REQ-031 SHALL verify backpressure: FIFO holds A5,5A,3C, out_ready=0 -> exactly 2 pops, state FULL, out_data=A5 held; out_ready=1 -> A5,5A,3C delivered on consecutive cycles.
REQ-032 SHALL verify empty boundary: single word 8'h7E, out_ready=1 -> one out_valid cycle, then out_valid=0 and rinc=0 while rempty=1.
REQ-033 SHALL verify mid-operation reset: rrst_n pulsed low in state FULL -> out_valid=0 asynchronously, no stale word emitted after release.
REQ-034 SHALL verify with FIFO_RD_STAT_EN: 65537 accepted words -> rd_cnt=1; a stalled cycle (out_ready=0) does not increment rd_cnt.
